// File: rtl/pingpong_bank_ctrl_pkg.sv
// Shared definitions for the ping-pong interleaver bank controller.
// Holds the default geometry and the read-side state encoding.
package wimax_pkg;

  localparam int BLOCK_LEN_DEF = 192;
  localparam int RAM_ADDR_W    = 9;

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_t;

endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// Handshake and RAM-address bundle between the bank controller and its neighbours.
// The controller uses the master view; upstream/consumer logic uses the slave view.
interface pingpong_bank_ctrl_if import wimax_pkg::*; #(
  parameter int ADDR_W = RAM_ADDR_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic              out_ready;
  logic              rden;
  logic [ADDR_W-1:0] rdaddress;
  logic              out_valid;
  logic              out_last;
  logic [1:0]        bank_full;
  logic              wr_bank;
  logic              rd_bank;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wren, wraddress, rden, rdaddress,
           out_valid, out_last, bank_full, wr_bank, rd_bank
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, wren, wraddress, rden, rdaddress,
           out_valid, out_last, bank_full, wr_bank, rd_bank
  );

endinterface

// File: rtl/pingpong_bank_ctrl_addr_gen.sv
// Per-side block walker: offset counter that wraps at the block end, flips the
// bank on wrap, and forms the RAM address as bank base plus offset.
module bank_addr_gen import wimax_pkg::*; #(
  parameter  int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter  int ADDR_W    = RAM_ADDR_W,
  localparam int CNT_W     = $clog2(BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              bank,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BLOCK_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BLOCK_LEN);

  logic [CNT_W-1:0] cnt;

  assign done = en & (cnt == LAST);
  assign addr = (bank ? BASE1 : '0) + ADDR_W'(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      bank <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        bank <= ~bank;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (reset) cnt <= LAST);

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank controller: the write side fills one bank while the read side
// drains the other; per-bank full flags hand blocks from writer to reader.
module pingpong_bank_ctrl import wimax_pkg::*; #(
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int RAM_LAT   = 1
) (
  input logic                  clk,
  input logic                  reset,
  pingpong_bank_ctrl_if.master bus
);

  logic [1:0]         bank_full;
  logic [1:0]         set_mask;
  logic [1:0]         clr_mask;
  logic               wr_bank;
  logic               rd_bank;
  logic               in_ready;
  logic               wren;
  logic               rden;
  logic               wr_done;
  logic               rd_done;
  logic [ADDR_W-1:0]  wraddress;
  logic [ADDR_W-1:0]  rdaddress;
  rd_state_t          state_q;
  rd_state_t          state_d;
  logic [RAM_LAT-1:0] vld_p;
  logic [RAM_LAT-1:0] last_p;

  assign in_ready = ~bank_full[wr_bank];
  assign wren     = bus.in_valid & in_ready;
  assign rden     = (state_q == RD_ACTIVE) & bus.out_ready;

  bank_addr_gen #(
    .BLOCK_LEN (BLOCK_LEN),
    .ADDR_W    (ADDR_W)
  ) u_wr_gen (
    .clk   (clk),
    .reset (reset),
    .en    (wren),
    .bank  (wr_bank),
    .addr  (wraddress),
    .done  (wr_done)
  );

  bank_addr_gen #(
    .BLOCK_LEN (BLOCK_LEN),
    .ADDR_W    (ADDR_W)
  ) u_rd_gen (
    .clk   (clk),
    .reset (reset),
    .en    (rden),
    .bank  (rd_bank),
    .addr  (rdaddress),
    .done  (rd_done)
  );

  // A finishing writer marks its bank full; a finishing reader frees its bank.
  // Both may fire in one cycle, always on opposite banks.
  assign set_mask = wr_done ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = rd_done ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Chaining straight into the next bank when it is already full keeps
  // back-to-back blocks bubble-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: begin
        if (bank_full[rd_bank]) begin
          state_d = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (rd_done) begin
          state_d = bank_full[~rd_bank] ? RD_ACTIVE : RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // out_valid/out_last ride alongside the RAM read latency
  if (RAM_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p  <= 1'b0;
        last_p <= 1'b0;
      end else begin
        vld_p  <= rden;
        last_p <= rd_done;
      end
    end
  end else begin : g_latn
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p  <= '0;
        last_p <= '0;
      end else begin
        vld_p  <= {vld_p[RAM_LAT-2:0], rden};
        last_p <= {last_p[RAM_LAT-2:0], rd_done};
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wren      = wren;
  assign bus.wraddress = wraddress;
  assign bus.rden      = rden;
  assign bus.rdaddress = rdaddress;
  assign bus.out_valid = vld_p[RAM_LAT-1];
  assign bus.out_last  = last_p[RAM_LAT-1];
  assign bus.bank_full = bank_full;
  assign bus.wr_bank   = wr_bank;
  assign bus.rd_bank   = rd_bank;

  a_no_set_clr_same_bank: assert property (@(posedge clk) disable iff (reset)
    (set_mask & clr_mask) == 2'b00);
  a_set_only_empty: assert property (@(posedge clk) disable iff (reset)
    wr_done |-> !bank_full[wr_bank]);
  a_clr_only_full: assert property (@(posedge clk) disable iff (reset)
    rd_done |-> bank_full[rd_bank]);

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl: RAM_LAT=1 and RAM_LAT=2 instances share
// stimulus; a RAM model and occupancy map check data order and bank ownership.
module tb_pingpong_bank_ctrl;
  import wimax_pkg::*;

  localparam int BL = 192;
  localparam int AW = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pingpong_bank_ctrl_if #(.ADDR_W(AW)) bus1 ();
  pingpong_bank_ctrl_if #(.ADDR_W(AW)) bus2 ();

  assign bus2.in_valid  = bus1.in_valid;
  assign bus2.out_ready = bus1.out_ready;

  pingpong_bank_ctrl #(.BLOCK_LEN(BL), .ADDR_W(AW), .RAM_LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  pingpong_bank_ctrl #(.BLOCK_LEN(BL), .ADDR_W(AW), .RAM_LAT(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit is_last(input logic [AW-1:0] a);
    return (int'(a) == BL - 1) || (int'(a) == 2 * BL - 1);
  endfunction

  // Reference model state, updated once per cycle at the falling edge
  int         cyc = 0;
  int         ram [0:2*BL-1];
  bit         occ [0:2*BL-1];
  int         exp_q [$];
  int         wdata = 0;
  bit         h1_v = 1'b0;
  bit         h1_last = 1'b0;
  int         h1_data = 0;
  logic [1:0] h2_v = '0;
  logic [1:0] h2_last = '0;
  int         ov1_cnt = 0;
  int         wr_total = 0;
  int         rd_idx = 0;
  int         rd_seq_err = 0;
  int         c_full0 = -1;
  int         c_rd0 = -1;
  int         cyc_rd0 = -1;
  int         cyc_rd383 = -1;
  int         d2_rd = -1;
  int         d2_ov = -1;
  int         d2_rd191 = -1;
  int         d2_last = -1;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      h1_v = 1'b0; h1_last = 1'b0; h1_data = 0; h2_v = '0; h2_last = '0;
      foreach (occ[i]) occ[i] = 1'b0;
      exp_q.delete();
      ov1_cnt = 0; wr_total = 0; rd_idx = 0; rd_seq_err = 0;
      c_full0 = -1; c_rd0 = -1; cyc_rd0 = -1; cyc_rd383 = -1;
      d2_rd = -1; d2_ov = -1; d2_rd191 = -1; d2_last = -1;
    end else begin
      chk("ov_lat1", 32'(bus1.out_valid), 32'(h1_v));
      if (bus1.out_valid) begin
        ov1_cnt++;
        chk("last1_addr", 32'(bus1.out_last), 32'(h1_last));
        chk("last1_every192", 32'(bus1.out_last), 32'(ov1_cnt % BL == 0));
        chk("data_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("data_order", h1_data, exp_q.pop_front());
      end
      chk("ov_lat2", 32'(bus2.out_valid), 32'(h2_v[1]));
      if (bus2.out_valid) begin
        chk("last2_addr", 32'(bus2.out_last), 32'(h2_last[1]));
        if (d2_ov < 0) d2_ov = cyc;
        if (bus2.out_last && d2_last < 0) d2_last = cyc;
      end
      if (bus1.bank_full[0] && c_full0 < 0) c_full0 = cyc;
      if (bus1.wren) begin
        chk("wr_into_full", 32'(occ[bus1.wraddress]), 32'd0);
        occ[bus1.wraddress] = 1'b1;
        ram[bus1.wraddress] = wdata;
        exp_q.push_back(wdata);
        wdata++;
        wr_total++;
      end
      h1_v    = bus1.rden;
      h1_last = 1'b0;
      if (bus1.rden) begin
        chk("rd_unwritten", 32'(occ[bus1.rdaddress]), 32'd1);
        occ[bus1.rdaddress] = 1'b0;
        h1_data = ram[bus1.rdaddress];
        h1_last = is_last(bus1.rdaddress);
        if (c_rd0 < 0) c_rd0 = cyc;
        if (rd_idx == 0) cyc_rd0 = cyc;
        if (rd_idx == 2 * BL - 1) cyc_rd383 = cyc;
        if (rd_idx < 2 * BL && int'(bus1.rdaddress) != rd_idx) rd_seq_err++;
        rd_idx++;
      end
      h2_v[1]    = h2_v[0];
      h2_last[1] = h2_last[0];
      h2_v[0]    = bus2.rden;
      h2_last[0] = bus2.rden && is_last(bus2.rdaddress);
      if (bus2.rden && d2_rd < 0) d2_rd = cyc;
      if (bus2.rden && int'(bus2.rdaddress) == BL - 1 && d2_rd191 < 0) d2_rd191 = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  initial begin
    bit found;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    sample();
    chk("rst_wr_bank", 32'(bus1.wr_bank), 32'd0);
    chk("rst_rd_bank", 32'(bus1.rd_bank), 32'd0);
    chk("rst_bank_full", 32'(bus1.bank_full), 32'd0);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst_rden", 32'(bus1.rden), 32'd0);
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus1.out_last), 32'd0);
    chk("rst_wraddress", 32'(bus1.wraddress), 32'd0);
    chk("rst_rdaddress", 32'(bus1.rdaddress), 32'd0);
    chk("rst_out_valid2", 32'(bus2.out_valid), 32'd0);

    // Fill bank 0 with reads held off
    tick();
    bus1.in_valid = 1'b1;
    for (int i = 0; i < BL; i++) begin
      sample();
      chk("wraddr_b0", 32'(bus1.wraddress), i);
      chk("in_ready_b0", 32'(bus1.in_ready), 32'd1);
      tick();
    end
    bus1.in_valid = 1'b0;
    sample();
    chk("b0_full", 32'(bus1.bank_full), 32'd1);
    chk("b0_wr_bank", 32'(bus1.wr_bank), 32'd1);
    chk("b0_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("b0_rden_held", 32'(bus1.rden), 32'd0);

    // Fill bank 1, then both banks are full and writes are refused
    tick();
    bus1.in_valid = 1'b1;
    for (int i = 0; i < BL; i++) begin
      sample();
      chk("wraddr_b1", 32'(bus1.wraddress), BL + i);
      tick();
    end
    sample();
    chk("both_full", 32'(bus1.bank_full), 32'd3);
    chk("both_full_in_ready", 32'(bus1.in_ready), 32'd0);
    chk("both_full_wren", 32'(bus1.wren), 32'd0);
    chk("both_full_wr_bank", 32'(bus1.wr_bank), 32'd0);

    // Drain one block; in_ready returns the cycle after address 191 issues
    tick();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      sample();
      if (k == 0) begin
        chk("first_rd_rden", 32'(bus1.rden), 32'd1);
        chk("first_rd_addr", 32'(bus1.rdaddress), 32'd0);
      end
      if (bus1.rden && int'(bus1.rdaddress) == BL - 1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rd191_issued", 32'(found), 32'd1);
    chk("in_ready_at_last_rd", 32'(bus1.in_ready), 32'd0);
    tick();
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    sample();
    chk("reopen_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("reopen_bank_full", 32'(bus1.bank_full), 32'd2);
    chk("reopen_rd_bank", 32'(bus1.rd_bank), 32'd1);
    chk("reopen_wraddr", 32'(bus1.wraddress), 32'd0);
    chk("reopen_wren", 32'(bus1.wren), 32'd1);
    for (int i = 1; i < BL; i++) begin
      tick();
      sample();
      chk("rewrite_b0", 32'(bus1.wraddress), i);
    end
    tick();
    bus1.in_valid = 1'b0;
    sample();
    chk("refull", 32'(bus1.bank_full), 32'd3);
    tick();
    bus1.out_ready = 1'b1;
    repeat (2 * BL + 10) tick();
    sample();
    chk("drain_bank_full", 32'(bus1.bank_full), 32'd0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_ov_count", 32'(ov1_cnt), 32'd576);

    // Continuous streaming on both sides
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b1;
    repeat (1000) tick();
    sample();
    chk("stream_first_rden", 32'(c_rd0 - c_full0), 32'd1);
    chk("stream_rd_seq_err", 32'(rd_seq_err), 32'd0);
    chk("stream_no_gap", 32'(cyc_rd383 - cyc_rd0), 32'd383);
    chk("stream_progress", 32'(ov1_cnt >= 576), 32'd1);
    chk("lat2_valid", 32'(d2_ov - d2_rd), 32'd2);
    chk("lat2_last", 32'(d2_last - d2_rd191), 32'd2);

    // Random handshakes over ten blocks
    tick();
    reset = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      bus1.in_valid  = (wr_total < 10 * BL) && ($urandom_range(0, 1) == 1);
      bus1.out_ready = ($urandom_range(0, 1) == 1);
      sample();
      if (ov1_cnt == 10 * BL) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rand_done", 32'(found), 32'd1);
    chk("rand_ov_count", 32'(ov1_cnt), 32'd1920);
    chk("rand_wr_count", 32'(wr_total), 32'd1920);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_bank_full", 32'(bus1.bank_full), 32'd0);

    // Reset while writing bank 1 index 100 and reading bank 0 index 50
    tick();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus1.in_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      sample();
      if (int'(bus1.wraddress) == BL + 49) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_reach_w49", 32'(found), 32'd1);
    tick();
    bus1.out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      sample();
      if (int'(bus1.wraddress) == BL + 99) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_reach_w99", 32'(found), 32'd1);
    tick();
    reset = 1'b1;
    sample();
    chk("mid_wraddr", 32'(bus1.wraddress), BL + 100);
    chk("mid_rdaddr", 32'(bus1.rdaddress), 32'd50);
    chk("mid_rden", 32'(bus1.rden), 32'd1);
    tick();
    reset = 1'b0;
    sample();
    chk("post_rst_bank_full", 32'(bus1.bank_full), 32'd0);
    chk("post_rst_wr_bank", 32'(bus1.wr_bank), 32'd0);
    chk("post_rst_rd_bank", 32'(bus1.rd_bank), 32'd0);
    chk("post_rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("post_rst_out_valid2", 32'(bus2.out_valid), 32'd0);
    chk("post_rst_wraddr", 32'(bus1.wraddress), 32'd0);
    chk("post_rst_rdaddr", 32'(bus1.rdaddress), 32'd0);
    chk("post_rst_rden", 32'(bus1.rden), 32'd0);
    chk("post_rst_in_ready", 32'(bus1.in_ready), 32'd1);
    tick();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
